pc_skip_sequencer: RTL

Program-counter sequencer that consumes the `skip` decision produced by the branch/skip controller from the comparison flags. On every retiring instruction it advances the PC by one instruction, by two on a taken skip, or loads a jump target. After a taken skip it squashes the already-fetched fall-through instruction for one cycle. It sits between the skip controller and instruction memory and owns the architectural PC.

---
 rtl/pc_skip_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pc_skip_sequencer.sv
// Architectural PC sequencer: advances by one instruction, by two on a taken skip,
// or loads a jump target, then squashes the fall-through fetch for one cycle.
// Optional feature macro: SKIP_STATS_EN adds the saturating 8-bit skipCount port.
module pc_skip_sequencer #(
  parameter int unsigned          PC_WIDTH    = 16,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = 16'h0000,
  parameter int unsigned          INSTR_BYTES = 2
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                stepEn,
  input  logic                stall,
  input  logic                skip,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jumpTarget,
  output logic [PC_WIDTH-1:0] PC,
  output logic                pcValid,
  output logic                squash,
`ifdef SKIP_STATS_EN
  output logic [7:0]          skipCount,
`endif
  output logic [1:0]          dbg_state
);

  // Handshake: a step is accepted only on a rising edge where stepEn=1, stall=0
  // and the FSM is in RUN; skip/jump/jumpTarget are qualifiers sampled on that edge
  // only. stall=1 freezes every register regardless of state.

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    SQUASH = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] STEP_ONE = PC_WIDTH'(INSTR_BYTES);
  localparam logic [PC_WIDTH-1:0] STEP_TWO = PC_WIDTH'(2 * INSTR_BYTES);

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                valid_q, valid_d;
  logic                squash_q, squash_d;
  logic                skip_taken;

`ifdef SKIP_STATS_EN
  logic [7:0] cnt_q, cnt_d;
`endif

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      squash_q <= squash_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    squash_d   = squash_q;
    skip_taken = 1'b0;
    if (!stall) begin
      unique case (state_q)
        BOOT: begin
          valid_d = 1'b1;
          state_d = RUN;
        end
        RUN: begin
          if (stepEn) begin
            // Jump wins over skip; PC arithmetic wraps silently at PC_WIDTH.
            if (jump) begin
              pc_d     = jumpTarget;
              squash_d = 1'b1;
              state_d  = SQUASH;
            end else if (skip) begin
              pc_d       = pc_q + STEP_TWO;
              squash_d   = 1'b1;
              state_d    = SQUASH;
              skip_taken = 1'b1;
            end else begin
              pc_d = pc_q + STEP_ONE;
            end
          end
        end
        SQUASH: begin
          squash_d = 1'b0;
          state_d  = RUN;
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

`ifdef SKIP_STATS_EN
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cnt_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (skip_taken && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'h01;
    end
  end

  assign skipCount = cnt_q;
`else
  logic unused_skip_taken;
  assign unused_skip_taken = skip_taken;
`endif

  assign PC        = pc_q;
  assign pcValid   = valid_q;
  assign squash    = squash_q;
  assign dbg_state = state_q;

endmodule
